mode_ctrl: RTL

Consumes the four debounced button levels (HS, VS, DF_UART, DF_VGA) produced by the debouncer stage and converts each press into a mode change. It keeps the display and serial mode registers and publishes every change as one configuration word over a valid/ready handshake to the VGA/UART configuration consumer. Changes that arrive while a transfer is outstanding are coalesced into the next transfer.

---
 rtl/mode_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mode_ctrl.sv
// ============================================================================
// mode_ctrl : button-driven display/serial mode registers with a coalescing
//             valid/ready configuration publisher.
// Optional feature macro: MODE_CTRL_BOOT_CFG_EN (offer reset config once).
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mode_ctrl #(
  parameter  int FMT_NUM = 4,
  parameter  int GAP     = 4,
  localparam int FMT_W   = $clog2(FMT_NUM),
  localparam int CFG_W   = 2 + 2 * FMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             HS,
  input  logic             VS,
  input  logic             DF_UART,
  input  logic             DF_VGA,
  output logic             hs_en,
  output logic             vs_en,
  output logic [FMT_W-1:0] uart_fmt,
  output logic [FMT_W-1:0] vga_fmt,
  output logic             cfg_valid,
  input  logic             cfg_ready,
  output logic [CFG_W-1:0] cfg_data
);

  localparam logic [FMT_W-1:0] C_FMT_LAST = FMT_W'(FMT_NUM - 1);
  localparam logic [7:0]       C_GAP      = 8'(GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_prev_hs;
  logic             r_prev_vs;
  logic             r_prev_du;
  logic             r_prev_dv;
  logic             r_dirty;
  logic [7:0]       r_gap_cnt;

  logic             w_rise_hs;
  logic             w_rise_vs;
  logic             w_rise_du;
  logic             w_rise_dv;
  logic             w_any_rise;
  logic             w_pending;
  logic             w_boot;
  logic             w_hs_nxt;
  logic             w_vs_nxt;
  logic [FMT_W-1:0] w_uf_nxt;
  logic [FMT_W-1:0] w_vf_nxt;
  logic [CFG_W-1:0] w_snap;

  function automatic logic [FMT_W-1:0] f_next_fmt(input logic [FMT_W-1:0] f);
    return (f == C_FMT_LAST) ? '0 : f + 1'b1;
  endfunction

  assign w_rise_hs  = HS      & ~r_prev_hs;
  assign w_rise_vs  = VS      & ~r_prev_vs;
  assign w_rise_du  = DF_UART & ~r_prev_du;
  assign w_rise_dv  = DF_VGA  & ~r_prev_dv;
  assign w_any_rise = w_rise_hs | w_rise_vs | w_rise_du | w_rise_dv;
  assign w_pending  = r_dirty | w_any_rise;

  // Post-update mode values; snapshots always capture these so a rise in the
  // snapshot cycle is never lost.
  assign w_hs_nxt = hs_en ^ w_rise_hs;
  assign w_vs_nxt = vs_en ^ w_rise_vs;
  assign w_uf_nxt = w_rise_du ? f_next_fmt(uart_fmt) : uart_fmt;
  assign w_vf_nxt = w_rise_dv ? f_next_fmt(vga_fmt)  : vga_fmt;
  assign w_snap   = {w_hs_nxt, w_vs_nxt, w_uf_nxt, w_vf_nxt};

`ifdef MODE_CTRL_BOOT_CFG_EN
  logic r_boot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_boot <= 1'b1;
    end else begin
      r_boot <= 1'b0;
    end
  end

  assign w_boot = r_boot;
`else
  assign w_boot = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_hs <= 1'b0;
      r_prev_vs <= 1'b0;
      r_prev_du <= 1'b0;
      r_prev_dv <= 1'b0;
      hs_en     <= 1'b0;
      vs_en     <= 1'b0;
      uart_fmt  <= '0;
      vga_fmt   <= '0;
    end else begin
      r_prev_hs <= HS;
      r_prev_vs <= VS;
      r_prev_du <= DF_UART;
      r_prev_dv <= DF_VGA;
      hs_en     <= w_hs_nxt;
      vs_en     <= w_vs_nxt;
      uart_fmt  <= w_uf_nxt;
      vga_fmt   <= w_vf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      cfg_valid <= 1'b0;
      cfg_data  <= '0;
      r_dirty   <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_rise || w_boot) begin
            r_state   <= S_SEND;
            cfg_valid <= 1'b1;
            cfg_data  <= w_snap;
          end
        end

        S_SEND: begin
          if (cfg_ready) begin
            if (GAP == 0) begin
              // Back-to-back: re-offer immediately when something changed.
              if (w_pending) begin
                cfg_data <= w_snap;
                r_dirty  <= 1'b0;
              end else begin
                r_state   <= S_IDLE;
                cfg_valid <= 1'b0;
              end
            end else begin
              r_state   <= S_HOLD;
              cfg_valid <= 1'b0;
              r_gap_cnt <= C_GAP;
              r_dirty   <= w_pending;
            end
          end else begin
            r_dirty <= w_pending;
          end
        end

        S_HOLD: begin
          if (r_gap_cnt <= 8'd1) begin
            if (w_pending) begin
              r_state   <= S_SEND;
              cfg_valid <= 1'b1;
              cfg_data  <= w_snap;
              r_dirty   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
            r_dirty   <= w_pending;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          cfg_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
